fft_butterfly_column: RTL and testbench
=======================================

// Module: fft_butterfly_column
// PURPOSE
//  One butterfly column of the integer FFT over Z/(2^SIZE+1), i.e. NODES parallel butterflies.
//  Absorbs the step counter and bus-mapped register file that were previously spread over
//  separate node/control instances. Each node has a runtime-programmable twiddle shift.
//  Columns are chained into the FFT network by in_*/out_* and sit on the global RD/WR/Addr bus.
// PARAMETERS
//  SIZE     4  data bits per value; each value is SIZE+1 bits (MSB set = value -1 = 2^SIZE)
//  NODES    4  butterflies in the column
//  IDWIDTH  8  Addr bits decoded
//  BASE_ID  0  first register id of this column
// PORTS
//  Clk       in   1                clock, rising edge
//  Reset_n   in   1                asynchronous reset, active low
//  RD        in   1                bus read strobe
//  WR        in   1                bus write strobe
//  Addr      in   GlobalAddrWidth  bus address; only [IDWIDTH-1:0] decoded
//  DataIn    in   GlobalDataWidth  bus write data
//  DataOut   out  GlobalDataWidth  bus read data; GlobalDataHighZ when not selected
//  in_l      in   NODES*(SIZE+1)   node k left operand at [k*(SIZE+1)+:SIZE+1]
//  in_r      in   NODES*(SIZE+1)   node k right operand
//  out_l     out  NODES*(SIZE+1)   node k left register
//  out_r     out  NODES*(SIZE+1)   node k right register
//  Enable    out  1                count != 0; column is stepping
//  Done      out  1                one-cycle pulse on the cycle count goes 1 -> 0
//  ScanIn    in   SIZE+1           scan data in (FFT_SCAN_EN only)
//  ScanOut   out  SIZE+1           scan data out = node NODES-1 right reg (FFT_SCAN_EN only)
//  ScanEnable in  1                shift scan chain this cycle (FFT_SCAN_EN only)
// BEHAVIOUR
//  Reset (async, Reset_n=0): out_l, out_r, shift regs, count := 0; Done := 0; Enable := 0.
//  Reset mid-run aborts immediately and produces no Done pulse.
//  Register map, id = Addr[IDWIDTH-1:0]-BASE_ID:
//   0 COUNT (rw); 1 STATUS (ro: bit0 Enable, bit1 sticky done, cleared on read);
//   2+2k node k left; 3+2k node k right (rw, bits [SIZE:0]);
//   2+2*NODES+k node k shift s_k (rw, range 0..2*SIZE-1; a written value >= 2*SIZE is taken modulo 2*SIZE).
//  Reads are combinational: DataOut is valid in the same cycle as RD and the id hit, zero-extended.
//  Writes take effect at the next Clk edge.
//  Butterfly with t = b*2^s_k mod M, where M = 2^SIZE+1:
//   out_l <= a + t mod M; out_r <= a - t mod M.
//   2^SIZE == -1, so s >= SIZE negates.
//   The canonical result is in 0..2^SIZE; the value 2^SIZE is encoded as {1,0...0}.
//   Operands with MSB set and nonzero low bits are treated as -1.
//  Step counter: a write to COUNT loads DataIn. While count != 0, every node updates from
//   in_l/in_r and count decrements by 1. Latency is one cycle per step.
//  Simultaneous events:
//   - COUNT write while running: reloads count; the current step still executes.
//   - Node register write while Enable: the bus write wins for that register only; all others step.
//   - COUNT write of 0 while running: stops without a Done pulse.
//   - Writing COUNT=1 gives exactly one step, followed by a Done pulse.
//  count wraps never; it saturates at 0.
// CONFIGURATION
//  FFT_SCAN_EN defined:
//   - Scan ports exist. The chain order is ScanIn -> n0.l -> n0.r -> n1.l -> ... -> n(NODES-1).r -> ScanOut.
//   - While ScanEnable is high, the chain shifts one value per cycle.
//   - Scan has priority over bus writes and over stepping; count is held.
//  FFT_SCAN_EN undefined: scan ports are absent and node registers are reachable only via the bus.
// STRUCTURE
//  Shared package fft_pkg: GlobalDataWidth/GlobalAddrWidth, GlobalDataHighZ, register offsets
//   (REG_COUNT, REG_STATUS, REG_NODE0), and the fermat_t value width function.
//  Sub-module fft_fermat_butterfly (combinational a, b, s -> x, y; SIZE parameter),
//   instantiated NODES times via generate.
// TESTING
//  1 Reset: hold Reset_n=0 mid-run with count=5 -> all out_* =0, Enable=0, no Done pulse after release.
//  2 SIZE=4: a=3, b=5, s=1, COUNT=1 -> out_l=0_1101 (13), out_r=0_1010 (10), Done pulses once.
//  3 SIZE=4: a=1_0000 (-1), b=1, s=4 -> out_l=0_1111 (15), out_r=0_0000.
//  4 COUNT=3 with the outputs looped back to the inputs -> exactly 3 steps, Enable high for 3 cycles,
//    STATUS bit1=1 then reads 0.
//  5 Write node1 left during a run -> node1.l = DataIn and the other registers stepped;
//    a COUNT reload to 2 mid-run extends the run.
//  6 FFT_SCAN_EN, NODES=2: shift in 1,2,3,4 -> ScanOut shows the old n1.r, n1.l, n0.r, n0.l in order;
//    count is unchanged throughout.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the integer FFT over Z/(2^SIZE+1): bus widths,
// register offsets, register-kind decode type and value width helper.
package fft_pkg;

   localparam int unsigned GlobalDataWidth = 16;
   localparam int unsigned GlobalAddrWidth = 16;
   localparam logic [GlobalDataWidth-1:0] GlobalDataHighZ = {GlobalDataWidth{1'bz}};

   localparam int unsigned REG_COUNT  = 0;
   localparam int unsigned REG_STATUS = 1;
   localparam int unsigned REG_NODE0  = 2;

   typedef enum logic [2:0] {
      RK_NONE,
      RK_COUNT,
      RK_STATUS,
      RK_LEFT,
      RK_RIGHT,
      RK_SHIFT
   } reg_kind_t;

   // Bits per fermat value: SIZE data bits plus the -1 flag bit.
   function automatic int unsigned fermat_t(input int unsigned size);
      return size + 1;
   endfunction

endpackage

// File: rtl/fft_butterfly_column_if.sv
// Register bus shared by all butterfly columns: read/write strobes,
// address and write data. Read data is returned on a separate tri-state port.
interface fft_butterfly_column_if;
   import fft_pkg::*;

   logic                       RD;
   logic                       WR;
   logic [GlobalAddrWidth-1:0] Addr;
   logic [GlobalDataWidth-1:0] DataIn;

   modport master (output RD, WR, Addr, DataIn);
   modport slave  (input  RD, WR, Addr, DataIn);

endinterface

// File: rtl/fft_fermat_butterfly.sv
// Combinational butterfly over Z/(2^SIZE+1):
//   t = b*2^s mod M, x = a + t mod M, y = a - t mod M.
module fft_fermat_butterfly
   import fft_pkg::*;
#(
   parameter int unsigned SIZE = 4
) (
   input  logic [fermat_t(SIZE)-1:0]  a,
   input  logic [fermat_t(SIZE)-1:0]  b,
   input  logic [$clog2(2*SIZE)-1:0]  s,
   output logic [fermat_t(SIZE)-1:0]  x,
   output logic [fermat_t(SIZE)-1:0]  y
);

   localparam int unsigned W  = fermat_t(SIZE);
   localparam int unsigned SW = $clog2(2*SIZE);
   localparam logic [W-1:0] NEG1 = W'(1 << SIZE);
   localparam logic [W:0]   MOD  = (W+1)'((1 << SIZE) + 1);

   logic [W-1:0]      an, bn;
   logic              neg;
   logic [SW-1:0]     sr;
   logic [2*SIZE-1:0] prod;
   logic [W:0]        red, t, sum, dif;

   // 2^s with s >= SIZE is -2^(s-SIZE); the shifted product is folded as lo - hi
   // because 2^SIZE == -1 mod M.
   always_comb begin
      an   = a[SIZE] ? NEG1 : a;
      bn   = b[SIZE] ? NEG1 : b;
      neg  = (s >= SW'(SIZE));
      sr   = neg ? s - SW'(SIZE) : s;
      prod = (2*SIZE)'(bn) << sr;
      if (prod[SIZE-1:0] >= prod[2*SIZE-1:SIZE])
         red = (W+1)'(prod[SIZE-1:0]) - (W+1)'(prod[2*SIZE-1:SIZE]);
      else
         red = (W+1)'(prod[SIZE-1:0]) + MOD - (W+1)'(prod[2*SIZE-1:SIZE]);
      t    = (neg && red != '0) ? MOD - red : red;
      sum  = (W+1)'(an) + t;
      if (sum >= MOD)
         sum = sum - MOD;
      dif  = ((W+1)'(an) >= t) ? (W+1)'(an) - t : (W+1)'(an) + MOD - t;
      x    = W'(sum);
      y    = W'(dif);
   end

endmodule

// File: rtl/fft_butterfly_column.sv
// One FFT butterfly column: NODES butterflies, step counter and bus-mapped
// register file. Optional scan chain through all node registers when
// FFT_SCAN_EN is defined.
module fft_butterfly_column
   import fft_pkg::*;
#(
   parameter int unsigned SIZE    = 4,
   parameter int unsigned NODES   = 4,
   parameter int unsigned IDWIDTH = 8,
   parameter int unsigned BASE_ID = 0
) (
   input  logic                          Clk,
   input  logic                          Reset_n,
   fft_butterfly_column_if.slave         bus,
   output logic [GlobalDataWidth-1:0]    DataOut,
   input  logic [NODES*(SIZE+1)-1:0]     in_l,
   input  logic [NODES*(SIZE+1)-1:0]     in_r,
   output logic [NODES*(SIZE+1)-1:0]     out_l,
   output logic [NODES*(SIZE+1)-1:0]     out_r,
   output logic                          Enable,
   output logic                          Done
`ifdef FFT_SCAN_EN
   ,
   input  logic [SIZE:0]                 ScanIn,
   output logic [SIZE:0]                 ScanOut,
   input  logic                          ScanEnable
`endif
);

   localparam int unsigned W  = fermat_t(SIZE);
   localparam int unsigned SW = $clog2(2*SIZE);
   localparam int unsigned NI = (NODES > 1) ? $clog2(NODES) : 1;

   logic [W-1:0]               lreg [NODES];
   logic [W-1:0]               rreg [NODES];
   logic [SW-1:0]              sreg [NODES];
   logic [W-1:0]               nx   [NODES];
   logic [W-1:0]               ny   [NODES];
   logic [GlobalDataWidth-1:0] count;
   logic                       done_q, sticky_q;
   logic [IDWIDTH-1:0]         id;
   logic [31:0]                id32;
   reg_kind_t                  kind;
   logic [NI-1:0]              node;
   logic [GlobalDataWidth-1:0] rdata;
   logic                       wr_count, rd_status;
   logic                       scan_shift;
   logic [W-1:0]               scan_in;
   logic                       unused_addr;

   assign id          = bus.Addr[IDWIDTH-1:0] - IDWIDTH'(BASE_ID);
   assign unused_addr = ^bus.Addr;
   assign Enable      = (count != '0);
   assign Done        = done_q;
   assign wr_count    = bus.WR && (kind == RK_COUNT);
   assign rd_status   = bus.RD && (kind == RK_STATUS);

`ifdef FFT_SCAN_EN
   assign scan_shift = ScanEnable;
   assign scan_in    = ScanIn;
   assign ScanOut    = rreg[NODES-1];
`else
   assign scan_shift = 1'b0;
   assign scan_in    = '0;
`endif

   // Decode the column-relative register id into a kind and node index.
   always_comb begin
      id32 = 32'(id);
      kind = RK_NONE;
      node = '0;
      if (id32 == REG_COUNT)
         kind = RK_COUNT;
      else if (id32 == REG_STATUS)
         kind = RK_STATUS;
      else if (id32 >= REG_NODE0 && id32 < REG_NODE0 + 2*NODES) begin
         kind = ((id32 - REG_NODE0) % 2 == 0) ? RK_LEFT : RK_RIGHT;
         node = NI'((id32 - REG_NODE0) / 2);
      end else if (id32 >= REG_NODE0 + 2*NODES && id32 < REG_NODE0 + 3*NODES) begin
         kind = RK_SHIFT;
         node = NI'(id32 - REG_NODE0 - 2*NODES);
      end
   end

   // Combinational read mux; bus is released whenever this column is not addressed.
   always_comb begin
      rdata = '0;
      case (kind)
         RK_COUNT:  rdata = count;
         RK_STATUS: rdata = GlobalDataWidth'({sticky_q, Enable});
         RK_LEFT:   rdata = GlobalDataWidth'(lreg[node]);
         RK_RIGHT:  rdata = GlobalDataWidth'(rreg[node]);
         RK_SHIFT:  rdata = GlobalDataWidth'(sreg[node]);
         default:   rdata = '0;
      endcase
      DataOut = (bus.RD && kind != RK_NONE) ? rdata : GlobalDataHighZ;
   end

   for (genvar k = 0; k < NODES; k++) begin : g_node
      fft_fermat_butterfly #(.SIZE(SIZE)) u_bf (
         .a (in_l[k*W +: W]),
         .b (in_r[k*W +: W]),
         .s (sreg[k]),
         .x (nx[k]),
         .y (ny[k])
      );
      assign out_l[k*W +: W] = lreg[k];
      assign out_r[k*W +: W] = rreg[k];
   end

   // Counter, status and node registers: scan shift beats bus writes, which beat stepping
   // per register; a COUNT write never suppresses the step already in progress.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         count    <= '0;
         done_q   <= 1'b0;
         sticky_q <= 1'b0;
         for (int unsigned k = 0; k < NODES; k++) begin
            lreg[k] <= '0;
            rreg[k] <= '0;
            sreg[k] <= '0;
         end
      end else if (scan_shift) begin
         done_q  <= 1'b0;
         if (rd_status)
            sticky_q <= 1'b0;
         lreg[0] <= scan_in;
         rreg[0] <= lreg[0];
         for (int unsigned k = 1; k < NODES; k++) begin
            lreg[k] <= rreg[k-1];
            rreg[k] <= lreg[k];
         end
      end else begin
         if (wr_count)
            count <= bus.DataIn;
         else if (Enable)
            count <= count - 1'b1;
         done_q <= Enable && (count == GlobalDataWidth'(1)) && !wr_count;
         if (done_q)
            sticky_q <= 1'b1;
         else if (rd_status)
            sticky_q <= 1'b0;
         for (int unsigned k = 0; k < NODES; k++) begin
            if (bus.WR && kind == RK_LEFT && node == NI'(k))
               lreg[k] <= bus.DataIn[W-1:0];
            else if (Enable)
               lreg[k] <= nx[k];
            if (bus.WR && kind == RK_RIGHT && node == NI'(k))
               rreg[k] <= bus.DataIn[W-1:0];
            else if (Enable)
               rreg[k] <= ny[k];
            if (bus.WR && kind == RK_SHIFT && node == NI'(k))
               sreg[k] <= SW'(bus.DataIn % GlobalDataWidth'(2*SIZE));
         end
      end
   end

endmodule

// File: tb/tb_fft_butterfly_column.sv
// Directed bench for fft_butterfly_column (SIZE=4). Scan steps are built
// only when FFT_SCAN_EN is defined, using a two-node column.
module tb_fft_butterfly_column;
   import fft_pkg::*;

   localparam int SIZE = 4;
`ifdef FFT_SCAN_EN
   localparam int NODES = 2;
`else
   localparam int NODES = 4;
`endif
   localparam int W = SIZE + 1;
   localparam int A_COUNT = 0;
   localparam int A_STATUS = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_butterfly_column_if bus ();
   wire  [GlobalDataWidth-1:0] data_out;
   logic [NODES*W-1:0] drv_l = '0, drv_r = '0;
   logic [NODES*W-1:0] in_l, in_r, out_l, out_r;
   logic loop = 1'b0;
   logic enable, done;
`ifdef FFT_SCAN_EN
   logic [W-1:0] scan_in = '0, scan_out;
   logic scan_en = 1'b0;
`endif

   assign in_l = loop ? out_l : drv_l;
   assign in_r = loop ? out_r : drv_r;

   fft_butterfly_column #(.SIZE(SIZE), .NODES(NODES), .IDWIDTH(8), .BASE_ID(0)) dut (
      .Clk        (clk),
      .Reset_n    (rst_n),
      .bus        (bus),
      .DataOut    (data_out),
      .in_l       (in_l),
      .in_r       (in_r),
      .out_l      (out_l),
      .out_r      (out_r),
      .Enable     (enable),
      .Done       (done)
`ifdef FFT_SCAN_EN
      ,
      .ScanIn     (scan_in),
      .ScanOut    (scan_out),
      .ScanEnable (scan_en)
`endif
   );

   int compared = 0;
   int mismatched = 0;
   int done_cnt = 0;
   int en_cnt = 0;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (enable) en_cnt++;
   end

   function automatic int a_l(input int k); return 2 + 2*k; endfunction
   function automatic int a_r(input int k); return 3 + 2*k; endfunction
   function automatic int a_s(input int k); return 2 + 2*NODES + k; endfunction
   function automatic logic [31:0] nl(input int k); return 32'(out_l[k*W +: W]); endfunction
   function automatic logic [31:0] nr(input int k); return 32'(out_r[k*W +: W]); endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input int addr, input int data);
      bus.Addr = 16'(addr);
      bus.DataIn = 16'(data);
      bus.WR = 1'b1;
      tick(1);
      bus.WR = 1'b0;
   endtask

   task automatic bus_read(input int addr, output logic [31:0] d);
      bus.Addr = 16'(addr);
      bus.RD = 1'b1;
      #1;
      d = 32'(data_out);
      tick(1);
      bus.RD = 1'b0;
   endtask

   task automatic set_in(input int k, input int a, input int b);
      drv_l[k*W +: W] = W'(a);
      drv_r[k*W +: W] = W'(b);
   endtask

   initial begin
      logic [31:0] d;
      int d0, e0;
      bus.RD = 1'b0;
      bus.WR = 1'b0;
      bus.Addr = '0;
      bus.DataIn = '0;

      #12 rst_n = 1'b1;
      tick(1);
      check("reset_out_l", 32'(out_l), 0);
      check("reset_out_r", 32'(out_r), 0);
      check("reset_enable", 32'(enable), 0);
      check("reset_done", 32'(done), 0);
      bus_read(A_COUNT, d);
      check("reset_count", d, 0);
      bus_read(A_STATUS, d);
      check("reset_status", d, 0);

      // Reset in the middle of a run
      for (int k = 0; k < NODES; k++) set_in(k, 3, 0);
      bus_write(A_COUNT, 5);
      tick(1);
      check("run_enable", 32'(enable), 1);
      check("run_n0_l", nl(0), 3);
      d0 = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("midreset_out_l", 32'(out_l), 0);
      check("midreset_out_r", 32'(out_r), 0);
      check("midreset_enable", 32'(enable), 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick(8);
      check("midreset_no_done", 32'(done_cnt - d0), 0);
      check("midreset_enable_after", 32'(enable), 0);

      // Single step: 3,5,s=1 and -1,1,s=12 (taken as 4)
      drv_l = '0;
      drv_r = '0;
      set_in(0, 3, 5);
      set_in(1, 16, 1);
      bus_write(a_s(0), 1);
      bus_write(a_s(1), 12);
      bus_read(a_s(1), d);
      check("shift_mod", d, 4);
      d0 = done_cnt;
      bus_write(A_COUNT, 1);
      check("count1_enable", 32'(enable), 1);
      tick(1);
      check("bf_3_5_s1_l", nl(0), 13);
      check("bf_3_5_s1_r", nr(0), 10);
      check("bf_m1_1_s4_l", nl(1), 15);
      check("bf_m1_1_s4_r", nr(1), 0);
      check("count1_done", 32'(done), 1);
      tick(1);
      check("count1_done_once", 32'(done_cnt - d0), 1);
      check("count1_enable_off", 32'(enable), 0);
      bus_read(A_STATUS, d);
      check("status_sticky", d, 2);
      bus_read(A_STATUS, d);
      check("status_cleared", d, 0);

      // Single step: 7,9,s=7 and MSB-set operand 1_0011 treated as -1
      set_in(0, 7, 9);
      set_in(1, 5'b1_0011, 0);
      bus_write(a_s(0), 7);
      bus_write(A_COUNT, 1);
      tick(1);
      check("bf_7_9_s7_l", nl(0), 3);
      check("bf_7_9_s7_r", nr(0), 11);
      check("bf_msb_l", nl(1), 16);
      check("bf_msb_r", nr(1), 16);
      tick(1);
      bus_read(A_STATUS, d);
      check("status_sticky2", d, 2);

      // Three looped-back steps
      bus_write(a_s(0), 1);
      loop = 1'b1;
      e0 = en_cnt;
      d0 = done_cnt;
      bus_write(A_COUNT, 3);
      tick(5);
      check("loop_enable_cycles", 32'(en_cnt - e0), 3);
      check("loop_done_once", 32'(done_cnt - d0), 1);
      check("loop_n0_l", nl(0), 11);
      check("loop_n0_r", nr(0), 14);
      check("loop_n1_l", nl(1), 4);
      check("loop_n1_r", nr(1), 0);
      bus_read(A_STATUS, d);
      check("loop_status", d, 2);
      bus_read(A_STATUS, d);
      check("loop_status_clr", d, 0);
      loop = 1'b0;

      // Node write during a run, then a COUNT reload extends the run
      set_in(0, 1, 0);
      set_in(1, 5, 0);
      e0 = en_cnt;
      d0 = done_cnt;
      bus_write(A_COUNT, 3);
      bus_write(a_l(1), 9);
      check("wr_run_n1_l", nl(1), 9);
      check("wr_run_n1_r", nr(1), 5);
      check("wr_run_n0_l", nl(0), 1);
      check("wr_run_n0_r", nr(0), 1);
      bus_write(A_COUNT, 2);
      tick(4);
      check("reload_enable_cycles", 32'(en_cnt - e0), 4);
      check("reload_done_once", 32'(done_cnt - d0), 1);
      check("reload_n1_l", nl(1), 5);

      // COUNT=0 while running stops silently
      d0 = done_cnt;
      bus_write(A_COUNT, 4);
      tick(1);
      bus_write(A_COUNT, 0);
      check("stop_enable", 32'(enable), 0);
      tick(3);
      check("stop_no_done", 32'(done_cnt - d0), 0);

`ifdef FFT_SCAN_EN
      // Scan chain shift with count held
      bus_write(a_l(0), 10);
      bus_write(a_r(0), 11);
      bus_write(a_l(1), 12);
      bus_write(a_r(1), 13);
      bus_write(A_COUNT, 5);
      scan_en = 1'b1;
      scan_in = 5'd1;
      #1;
      check("scan_out_n1r", 32'(scan_out), 13);
      tick(1);
      check("scan_out_n1l", 32'(scan_out), 12);
      scan_in = 5'd2;
      tick(1);
      check("scan_out_n0r", 32'(scan_out), 11);
      scan_in = 5'd3;
      tick(1);
      check("scan_out_n0l", 32'(scan_out), 10);
      scan_in = 5'd4;
      tick(1);
      check("scan_out_first_in", 32'(scan_out), 1);
      bus_read(A_COUNT, d);
      check("scan_count_held", d, 5);
      check("scan_enable_held", 32'(enable), 1);
      scan_en = 1'b0;
      bus_write(A_COUNT, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
